// File: rtl/result_transmitter_if.sv
// Result word handshake between the result producer and the SPI transmitter.
//   tx_data  : N-bit result word (producer -> transmitter)
//   tx_valid : tx_data is valid (producer -> transmitter)
//   tx_ready : holding buffer empty (transmitter -> producer)
interface result_transmitter_if #(
  parameter int unsigned N = 80
);
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/result_transmitter.sv
// SPI mode-0 slave transmitter: returns one buffered N-bit result word per
// chip-select frame to the Raspberry Pi, MSB first.
//   clk, rst  : system clock, synchronous active-high reset
//   tx        : result word handshake (slave side)
//   RPiclk    : SPI clock from the Pi (asynchronous)
//   cs1       : SPI chip select from the Pi, active-low (asynchronous)
//   MISO      : serial data to the Pi
//   tx_busy   : frame in progress (SHIFT or WAIT_CS)
//   tx_done   : pulse, all N bits sampled by the Pi
//   tx_abort  : pulse, cs1 rose before N bits completed
//   underrun  : pulse, frame started with an empty holding buffer
module result_transmitter #(
  parameter int unsigned N = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  result_transmitter_if.slave    tx,
  input  logic                   RPiclk,
  input  logic                   cs1,
  output logic                   MISO,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_abort,
  output logic                   underrun
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t         state;
  logic [N-1:0]   buf_word;
  logic           buf_full;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;

  logic           sclk_meta, sclk_sync, sclk_dly;
  logic           cs_meta, cs_sync, cs_dly;
  logic [1:0]     settle;
  logic           armed;

  logic           cs_fall, cs_rise, sclk_rise, sclk_fall;

  // Edge events on the synchronized SPI pins
  always_comb begin
    cs_fall   = armed & cs_dly & ~cs_sync;
    cs_rise   = ~cs_dly & cs_sync;
    sclk_rise = ~sclk_dly & sclk_sync;
    sclk_fall = sclk_dly & ~sclk_sync;
  end

  assign tx.tx_ready = ~buf_full;

  // Synchronizers, holding buffer and frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_dly  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_dly    <= 1'b1;
      settle    <= 2'd0;
      armed     <= 1'b0;
      state     <= IDLE;
      buf_word  <= '0;
      buf_full  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      MISO      <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sclk_meta <= RPiclk;
      sclk_sync <= sclk_meta;
      sclk_dly  <= sclk_sync;
      cs_meta   <= cs1;
      cs_sync   <= cs_meta;
      cs_dly    <= cs_sync;

      // After reset the chain holds forced values for a few cycles; only
      // accept a frame once cs1 has really been seen high, so a cs1 that
      // was already low through reset does not start a frame.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_sync) armed <= 1'b1;

      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      underrun <= 1'b0;

      // Capture only into an empty buffer; a frame start can therefore only
      // clear a buffer that did not capture in the same cycle.
      if (tx.tx_valid && !buf_full) begin
        buf_word <= tx.tx_data;
        buf_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (cs_fall) begin
            state    <= SHIFT;
            tx_busy  <= 1'b1;
            cnt      <= '0;
            shreg    <= buf_full ? buf_word : '0;
            MISO     <= buf_full & buf_word[N-1];
            underrun <= ~buf_full;
            if (buf_full) buf_full <= 1'b0;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state    <= IDLE;
            tx_busy  <= 1'b0;
            tx_abort <= 1'b1;
            cnt      <= '0;
            shreg    <= '0;
            MISO     <= 1'b0;
          end else if (sclk_rise) begin
            if (cnt != CW'(N)) cnt <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              state   <= WAIT_CS;
              tx_done <= 1'b1;
              MISO    <= 1'b0;
            end
          end else if (sclk_fall && cnt < CW'(N)) begin
            shreg <= {shreg[N-2:0], 1'b0};
            MISO  <= shreg[N-2];
          end
        end

        WAIT_CS: begin
          MISO <= 1'b0;
          if (cs_rise) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            cnt     <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
          MISO    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_transmitter.sv
// Scoreboard bench for result_transmitter: expected frame events are queued
// when stimulus is issued; a monitor pops and compares on every DUT pulse.
module tb_result_transmitter;

  localparam int unsigned N  = 80;
  localparam int unsigned HP = 8;

  localparam int K_DONE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_UNDER = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic RPiclk, cs1;
  logic MISO, tx_busy, tx_done, tx_abort, underrun;

  result_transmitter_if #(.N(N)) tx_if ();

  result_transmitter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (tx_if.slave),
    .RPiclk   (RPiclk),
    .cs1      (cs1),
    .MISO     (MISO),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_abort (tx_abort),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  exp_t         exp_q[$];
  logic [N-1:0] rx;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input logic [N-1:0] word);
    exp_t e;
    e.kind = kind;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the next queued event
  always @(negedge clk) begin
    if (!rst && (tx_done || tx_abort || underrun)) begin
      int   kind;
      exp_t e;
      kind = tx_done ? K_DONE : (tx_abort ? K_ABORT : K_UNDER);
      n_cmp++;
      if (int'(tx_done) + int'(tx_abort) + int'(underrun) > 1) begin
        n_err++;
        $display("FAIL pulse_exclusive: done=%b abort=%b underrun=%b", tx_done, tx_abort, underrun);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: kind %0d with no event expected", kind);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind) begin
          n_err++;
          $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
        end else if (kind == K_DONE && rx !== e.word) begin
          n_err++;
          $display("FAIL frame_word: got %h, expected %h", rx, e.word);
        end
      end
    end
  end

  task automatic load_word(input logic [N-1:0] w, output int waited);
    waited = 0;
    @(negedge clk);
    tx_if.tx_data  = w;
    tx_if.tx_valid = 1'b1;
    while (!tx_if.tx_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_timeout: tx_ready stayed %b, expected 1", tx_if.tx_ready);
    end
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic sclk_pulse();
    @(negedge clk);
    RPiclk = 1'b1;
    rx = {rx[N-2:0], MISO};
    repeat (HP) @(negedge clk);
    RPiclk = 1'b0;
    repeat (HP - 1) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs1 = 1'b0;
    rx  = '0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    cs1 = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic spi_frame(input int nbits, input int extra);
    cs_low();
    for (int i = 0; i < nbits; i++) sclk_pulse();
    for (int i = 0; i < extra; i++) begin
      sclk_pulse();
      chk("wait_cs_miso", N'(rx[0]), N'(0));
      chk("wait_cs_busy", N'(tx_busy), N'(1));
    end
    cs_high();
  endtask

  initial begin
    int           t;
    logic [N-1:0] w;

    rst = 1'b1;
    RPiclk = 1'b0;
    cs1 = 1'b1;
    tx_if.tx_data = '0;
    tx_if.tx_valid = 1'b0;
    rx = '0;
    repeat (5) @(negedge clk);
    chk("reset_miso",  N'(MISO), N'(0));
    chk("reset_ready", N'(tx_if.tx_ready), N'(1));
    chk("reset_busy",  N'(tx_busy), N'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Empty buffer at frame start: underrun, zero word, still done
    push_exp(K_UNDER, '0);
    push_exp(K_DONE, '0);
    spi_frame(N, 0);

    // Full frame of a loaded word
    w = 80'h8000_0000_0000_0000_0001;
    load_word(w, t);
    chk("ready_after_load", N'(tx_if.tx_ready), N'(0));
    push_exp(K_DONE, w);
    spi_frame(N, 0);
    chk("ready_after_frame", N'(tx_if.tx_ready), N'(1));
    chk("idle_miso", N'(MISO), N'(0));
    chk("idle_busy", N'(tx_busy), N'(0));

    // Abort after 20 bits, then an underrunning frame
    w = {10{8'hA5}};
    load_word(w, t);
    push_exp(K_ABORT, '0);
    spi_frame(20, 0);
    chk("abort_busy", N'(tx_busy), N'(0));
    chk("abort_miso", N'(MISO), N'(0));
    chk("abort_ready", N'(tx_if.tx_ready), N'(1));
    push_exp(K_UNDER, '0);
    push_exp(K_DONE, '0);
    spi_frame(N, 0);

    // Refill during a frame; third word waits for the next frame start
    load_word(80'h1111_2222_3333_4444_5555, t);
    push_exp(K_DONE, 80'h1111_2222_3333_4444_5555);
    push_exp(K_DONE, 80'hCAFE_BABE_DEAD_BEEF_0F0F);
    fork
      spi_frame(N, 0);
      begin
        repeat (100) @(negedge clk);
        load_word(80'hCAFE_BABE_DEAD_BEEF_0F0F, t);
        chk("b_wait_cycles", N'(t), N'(0));
        chk("b_ready_low", N'(tx_if.tx_ready), N'(0));
      end
    join
    push_exp(K_DONE, 80'h0F0F_1234_5678_9ABC_DEF0);
    fork
      begin
        load_word(80'h0F0F_1234_5678_9ABC_DEF0, t);
        chk("c_waited", N'(t >= 20), N'(1));
      end
      begin
        repeat (20) @(negedge clk);
        chk("c_blocked", N'(tx_if.tx_ready), N'(0));
        spi_frame(N, 0);
      end
    join
    spi_frame(N, 0);

    // Extra clocks after the last bit are ignored
    w = 80'h0123_4567_89AB_CDEF_FEDC;
    load_word(w, t);
    push_exp(K_DONE, w);
    spi_frame(N, 5);

    // Reset mid-frame with cs1 held low
    load_word({5{16'hFFFF}}, t);
    cs_low();
    for (int i = 0; i < 40; i++) sclk_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_miso",  N'(MISO), N'(0));
    chk("midrst_ready", N'(tx_if.tx_ready), N'(1));
    chk("midrst_busy",  N'(tx_busy), N'(0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk_pulse();
      chk("post_rst_miso", N'(rx[0]), N'(0));
      chk("post_rst_busy", N'(tx_busy), N'(0));
    end
    cs_high();
    push_exp(K_UNDER, '0);
    push_exp(K_DONE, '0);
    spi_frame(N, 0);

    repeat (10) @(negedge clk);
    chk("queue_drained", N'(exp_q.size()), N'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 Parameter: N, default 80, frame length in bits (one SPI frame, MSB first).
REQ-002 clk  input  1  FPGA system clock; all logic is in this single domain.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 tx_data  input  N  result word to return to the Raspberry Pi.
REQ-005 tx_valid  input  1  tx_data is valid.
REQ-006 tx_ready  output  1  holding buffer empty; a word is accepted on tx_valid & tx_ready.
REQ-007 RPiclk  input  1  SPI clock from the Pi, mode 0, asynchronous to clk.
REQ-008 cs1  input  1  SPI chip select from the Pi, active-low, asynchronous to clk.
REQ-009 MISO  output  1  serial data to the Pi.
REQ-010 tx_busy  output  1  high while in SHIFT or WAIT_CS.
REQ-011 tx_done  output  1  one-cycle pulse when all N bits have been sampled by the Pi.
REQ-012 tx_abort  output  1  one-cycle pulse when cs1 rises before N bits complete.
REQ-013 underrun  output  1  one-cycle pulse when a frame starts with the holding buffer empty.

Function
REQ-014 RPiclk and cs1 each pass through a 2-flop synchronizer; the synchronizer reset values are RPiclk=0 and cs1=1.
REQ-015 Edge detection uses the synchronized signals and a third delay flop. Detected events are: cs fall, cs rise, sclk rise and sclk fall.
REQ-016 Timing requirement on the Pi side: RPiclk high and low phases each last at least 4 clk periods. The cs1 setup and hold to the RPiclk edges also last at least 4 clk periods.
REQ-017 Holding buffer: one N-bit register plus a buf_full flag.
  - tx_ready = ~buf_full (combinational).
  - tx_valid & tx_ready captures tx_data and sets buf_full on the next edge.
REQ-018 FSM states are IDLE, SHIFT and WAIT_CS.
REQ-019 IDLE to SHIFT on cs fall. In that cycle:
  - shift register loads the buffer content and buf_full clears.
  - If the buffer is empty, the shift register loads all zeros and underrun pulses.
  - The bit counter clears.
REQ-020 Frame-start loading and buffer capture in the same cycle: loading takes precedence. Because tx_ready is derived from the pre-edge buf_full, a full buffer never captures a word in that cycle.
REQ-021 MISO in SHIFT is the registered MSB of the shift register. The first bit is valid at most 4 clk cycles after cs1 falls at the pin.
REQ-022 SHIFT, on sclk rise: bit counter increments.
REQ-023 SHIFT, on sclk fall with counter < N: shift register shifts left by one, filling with 0, so MISO presents the next bit.
REQ-024 SHIFT to WAIT_CS when the counter reaches N, on the N-th sclk rise; tx_done pulses in that cycle.
REQ-025 WAIT_CS: MISO=0. Further RPiclk edges are ignored. Goes to IDLE on cs rise.
REQ-026 SHIFT to IDLE on cs rise with counter < N. In that cycle:
  - tx_abort pulses.
  - The in-flight word is discarded and is not returned to the buffer.
  - The counter clears.
REQ-027 IDLE: MISO=0 and RPiclk edges are ignored.
REQ-028 Bit counter width is $clog2(N+1). It never wraps; it saturates at N.
REQ-029 tx_done, tx_abort and underrun are mutually exclusive in any cycle.
REQ-030 The buffer may be refilled at any time, including during SHIFT. The new word is sent only in the next frame.

Reset
REQ-031 While rst is high, on each clk edge:
  - FSM returns to IDLE.
  - Shift register, buffer, buf_full and counter clear.
  - Synchronizers load RPiclk=0 and cs1=1.
REQ-032 Output values during and after reset: MISO=0, tx_ready=1, tx_busy=0, tx_done=0, tx_abort=0, underrun=0.
REQ-033 Reset asserted mid-frame abandons the frame without pulsing tx_abort. After reset, the block waits for a fresh cs fall; it does not resume on a cs1 level that is already low.

Verification
REQ-034 Load tx_data=80'h8000_0000_0000_0000_0001 (N=80), then run a full 80-clock frame with RPiclk half-period 8 clk. Required: MISO sampled on RPiclk rising edges reads the word MSB first; tx_done pulses once; tx_ready=1 afterwards.
REQ-035 Frame start with the buffer empty. Required: underrun pulses one cycle after the cs fall is detected; all 80 sampled bits are 0; tx_done still pulses.
REQ-036 Load 80'hA5...A5, then raise cs1 after 20 RPiclk cycles. Required: tx_abort pulses; FSM goes to IDLE; MISO=0; the next frame with an empty buffer underruns.
REQ-037 Load word A. During A's frame, present word B with tx_valid held high. Required: B is accepted immediately (tx_ready=1 after A loads); a second frame returns B; a third tx_valid during B's frame waits until B's frame starts.
REQ-038 Assert rst at bit 40 of a frame while cs1 stays low, then release it. Required: outputs take their reset values; no tx_abort pulse; MISO stays 0 until cs1 rises and falls again.
REQ-039 Issue 5 extra RPiclk pulses after bit 80 with cs1 still low. Required: MISO=0, no second tx_done, FSM stays in WAIT_CS until cs1 rises.
